mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the fetch stage (read-only) and the memory stage (load/store). It accepts requests from both requesters, picks one per access with data-side priority plus a fetch anti-starvation limit, sequences the memory's issue/latency/response phases through an FSM, and returns registered read data to the owner. It sits between the pipeline stages and the memory model, replacing their direct memory port wiring.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the mem_op_en cycle to valid mem_rd_data; legal range 1..15
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  pulse: discard response of any in-flight fetch (jump taken)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle fetch response strobe
- if_rdata  out  DATA_W  fetch read data, valid with if_rvalid
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  one-cycle completion strobe (loads and stores)
- dm_rdata  out  DATA_W  load data; 0 for stores
- mem_addr  out  ADDR_W  memory address
- mem_rd_wr  out  1  0 = read, 1 = write
- mem_op_en  out  1  memory operation strobe, one cycle per access
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any request, grant one (combinational if_gnt/dm_gnt, at most one high); latch addr, we, wdata, owner into command registers; go to ISSUE. No request: stay.
- ISSUE: mem_op_en=1, mem_addr/mem_rd_wr/mem_wr_data from command registers (fetch: mem_rd_wr=0, mem_wr_data=0); load latency counter with MEM_LAT; go to WAIT.
- WAIT: decrement counter; on the cycle counter equals 1, register mem_rd_data (0 for stores) into owner's rdata, set owner's rvalid for the next cycle, go to IDLE.
- Arbitration: dm_req wins, unless starve counter == STARVE_MAX and if_req high, then fetch wins.
- Starve counter: +1 on each dm grant while if_req high; cleared on if grant, or on dm grant with if_req low; saturates at STARVE_MAX.
- Flush: if_flush high in any cycle from a fetch grant through its WAIT completion marks that access dropped; memory access still completes, if_rvalid suppressed. if_flush in the same IDLE cycle as an if_gnt also drops it. Flush never affects data accesses.
- Requester dropping req before gnt is legal; nothing issued.
- mem_op_en, mem_addr, mem_rd_wr, mem_wr_data are 0 outside ISSUE.

## Timing

- Grant at cycle T (IDLE); mem_op_en at T+1; mem_rd_data sampled end of T+1+MEM_LAT; rvalid/rdata at T+2+MEM_LAT for exactly one cycle.
- Next grant possible at T+2+MEM_LAT (same cycle as rvalid): one access per MEM_LAT+2 cycles.
- rdata holds its value until the owner's next response.
- Reset (async, any state): FSM to IDLE, counters and starve counter 0, drop flag 0, all outputs 0 including rdata; in-flight access discarded, no rvalid after release.

## Test plan

- MEM_LAT=1, single load dm_addr=0x40, memory returns 0xDEADBEEF -> dm_gnt at T, mem_op_en at T+1 with mem_rd_wr=0, dm_rvalid with dm_rdata=0xDEADBEEF at T+3.
- Store dm_addr=0x10, dm_wdata=0x12345678 -> mem_rd_wr=1, mem_wr_data=0x12345678 at T+1; dm_rvalid with dm_rdata=0 at T+3; if_rvalid stays 0.
- if_req and dm_req held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; grants spaced exactly MEM_LAT+2 cycles.
- Fetch 0x100 granted, if_flush pulsed during WAIT -> mem_op_en still fires, if_rvalid never asserts, next grant on schedule.
- MEM_LAT=3 -> rvalid exactly 5 cycles after grant; busy high for 4 cycles.
- reset asserted mid-WAIT of a load -> all outputs 0 immediately; after release no dm_rvalid, next dm_req granted in first IDLE cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared request/response/memory bundle between pipeline stages, the arbiter and the memory.
// No logic of its own: purely wiring, zero latency.
// Requests hold their req until gnt; responses are single-cycle strobes with no backpressure.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_wr;
  logic              mem_op_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_rd_wr, mem_op_en, mem_wr_data,
    input  mem_rd_data
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_addr, mem_rd_wr, mem_op_en, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one unified memory between fetch (read-only) and data (load/store) with data priority.
// Grant at T, mem_op_en at T+1, rvalid/rdata at T+2+MEM_LAT; one access per MEM_LAT+2 cycles.
// Requesters hold req until gnt; fetch wins after STARVE_MAX data grants; responses cannot stall.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  mem_arbiter_if.slave    bus,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic              cmd_we_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              cmd_fetch_q;
  logic [3:0]        lat_cnt_q;
  logic [3:0]        starve_q;
  logic              drop_q;
  logic              grant_if, grant_dm;
  logic              last_wait;
  logic              if_rvalid_q, dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  // Pick the owner of the next access: data first unless fetch has waited too long
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (bus.if_req && (!bus.dm_req || starve_q == STARVE_LIM)) grant_if = 1'b1;
      else if (bus.dm_req)                                         grant_dm = 1'b1;
    end
  end

  assign last_wait = (state_q == WAIT) && (lat_cnt_q == 4'd1);

  // Next-state logic for the issue / latency sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_if || grant_dm) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the winning request; fetches are forced to read with zero write data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_addr_q  <= '0;
      cmd_we_q    <= 1'b0;
      cmd_wdata_q <= '0;
      cmd_fetch_q <= 1'b0;
    end else if (grant_if) begin
      cmd_addr_q  <= bus.if_addr;
      cmd_we_q    <= 1'b0;
      cmd_wdata_q <= '0;
      cmd_fetch_q <= 1'b1;
    end else if (grant_dm) begin
      cmd_addr_q  <= bus.dm_addr;
      cmd_we_q    <= bus.dm_we;
      cmd_wdata_q <= bus.dm_wdata;
      cmd_fetch_q <= 1'b0;
    end
  end

  // Latency countdown: loaded in ISSUE, reaches 1 on the cycle memory data is valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  lat_cnt_q <= '0;
    else if (state_q == ISSUE)  lat_cnt_q <= LAT_INIT;
    else if (state_q == WAIT)   lat_cnt_q <= lat_cnt_q - 4'd1;
  end

  // Count data grants that overtook a waiting fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             starve_q <= '0;
    else if (grant_if)     starve_q <= '0;
    else if (grant_dm) begin
      if (!bus.if_req)                  starve_q <= '0;
      else if (starve_q != STARVE_LIM)  starve_q <= starve_q + 4'd1;
    end
  end

  // A flush anywhere from fetch grant to completion drops that fetch's response
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                   drop_q <= 1'b0;
    else if (grant_if)                                           drop_q <= bus.if_flush;
    else if (grant_dm)                                           drop_q <= 1'b0;
    else if (state_q != IDLE && cmd_fetch_q && bus.if_flush)     drop_q <= 1'b1;
  end

  // Register memory data into the owner's response; stores complete with zero data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if (last_wait) begin
        if (cmd_fetch_q) begin
          if (!drop_q && !bus.if_flush) begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= bus.mem_rd_data;
          end
        end else begin
          dm_rvalid_q <= 1'b1;
          dm_rdata_q  <= cmd_we_q ? '0 : bus.mem_rd_data;
        end
      end
    end
  end

  // Memory command is driven only during ISSUE and is zero otherwise
  always_comb begin
    bus.mem_op_en   = (state_q == ISSUE);
    bus.mem_addr    = '0;
    bus.mem_rd_wr   = 1'b0;
    bus.mem_wr_data = '0;
    if (state_q == ISSUE) begin
      bus.mem_addr    = cmd_addr_q;
      bus.mem_rd_wr   = cmd_we_q;
      bus.mem_wr_data = cmd_wdata_q;
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against a schedule model.
// Model predicts grants, memory commands and responses per cycle from access start times.
// A second instance with MEM_LAT=3 checks the longer response spacing.
module tb_mem_arbiter;
  localparam int LAT  = 1;
  localparam int SMAX = 4;
  localparam int LAT3 = 3;

  bit   clk = 1'b0;
  logic reset;
  logic busy, busy3;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy));

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .busy(busy3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'h1000_0001 * 32'(i + 3)) ^ 32'h5A5A_A5A5;
  endfunction

  // Memory: data valid exactly MEM_LAT cycles after the op_en cycle, garbage otherwise
  logic [31:0] mem_arr [64];
  bit          mem_wr  [64];
  logic [31:0] mem_pend;
  int          mem_cnt = 0;
  bit          mem_active = 1'b0;

  always @(posedge clk) begin
    int i;
    #1;
    if (mem_active) mem_cnt++;
    if (bus.mem_op_en) begin
      i = int'(bus.mem_addr[7:2]);
      if (bus.mem_rd_wr) begin
        mem_arr[i] = bus.mem_wr_data;
        mem_wr[i]  = 1'b1;
      end
      mem_pend   = mem_wr[i] ? mem_arr[i] : init_word(i);
      mem_active = 1'b1;
      mem_cnt    = 0;
    end
    bus.mem_rd_data = (mem_active && mem_cnt == LAT) ? mem_pend : $urandom;
  end

  // Reference model state
  logic [31:0] ref_mem [64];
  int          t, free_at, starve, p_op, p_resp;
  bit          p_fetch, p_we, p_drop;
  logic [31:0] p_addr, p_wdata, p_data, exp_dm_rdata, exp_if_rdata;
  bit          obs_if_gnt, obs_dm_gnt;

  task automatic model_reset();
    free_at = 0; starve = 0; p_op = -1; p_resp = -1;
    p_fetch = 1'b0; p_we = 1'b0; p_drop = 1'b0;
    exp_dm_rdata = '0; exp_if_rdata = '0;
  endtask

  task automatic model_check();
    bit idle, op, resp, eg_if, eg_dm;
    int idx;
    idle = (t >= free_at);
    op   = (t == p_op);
    resp = (t == p_resp);
    if (resp && !p_fetch)           exp_dm_rdata = p_we ? 32'h0 : p_data;
    if (resp && p_fetch && !p_drop) exp_if_rdata = p_data;
    check("dm_rvalid", bus.dm_rvalid, resp && !p_fetch);
    check("if_rvalid", bus.if_rvalid, resp && p_fetch && !p_drop);
    check("dm_rdata", bus.dm_rdata, exp_dm_rdata);
    if (resp && p_fetch && !p_drop) check("if_rdata", bus.if_rdata, exp_if_rdata);
    check("busy", busy, !idle);
    check("mem_op_en", bus.mem_op_en, op);
    if (op) begin
      check("mem_addr", bus.mem_addr, p_addr);
      check("mem_rd_wr", bus.mem_rd_wr, p_we);
      if (p_fetch || p_we) check("mem_wr_data", bus.mem_wr_data, p_fetch ? 32'h0 : p_wdata);
    end else begin
      check("mem_addr_idle", bus.mem_addr, 0);
      check("mem_rd_wr_idle", bus.mem_rd_wr, 0);
      check("mem_wr_data_idle", bus.mem_wr_data, 0);
    end
    if (bus.if_flush && p_fetch && t < p_resp) p_drop = 1'b1;
    eg_if = idle && bus.if_req && (!bus.dm_req || starve == SMAX);
    eg_dm = idle && bus.dm_req && !eg_if;
    check("if_gnt", bus.if_gnt, eg_if);
    check("dm_gnt", bus.dm_gnt, eg_dm);
    obs_if_gnt = bus.if_gnt;
    obs_dm_gnt = bus.dm_gnt;
    if (eg_if || eg_dm) begin
      p_fetch = eg_if;
      p_op    = t + 1;
      p_resp  = t + 2 + LAT;
      free_at = p_resp;
      p_addr  = eg_if ? bus.if_addr : bus.dm_addr;
      p_we    = eg_dm && bus.dm_we;
      p_wdata = bus.dm_wdata;
      p_drop  = eg_if && bus.if_flush;
      idx     = int'(p_addr[7:2]);
      if (p_we) ref_mem[idx] = p_wdata;
      p_data  = ref_mem[idx];
      if (eg_if)           starve = 0;
      else if (bus.if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else                 starve = 0;
    end
    t++;
  endtask

  // Inputs are set at posedge+1; outputs checked at the following negedge
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string pfx);
    check({pfx, "_if_gnt"},      bus.if_gnt, 0);
    check({pfx, "_dm_gnt"},      bus.dm_gnt, 0);
    check({pfx, "_if_rvalid"},   bus.if_rvalid, 0);
    check({pfx, "_dm_rvalid"},   bus.dm_rvalid, 0);
    check({pfx, "_if_rdata"},    bus.if_rdata, 0);
    check({pfx, "_dm_rdata"},    bus.dm_rdata, 0);
    check({pfx, "_mem_op_en"},   bus.mem_op_en, 0);
    check({pfx, "_mem_addr"},    bus.mem_addr, 0);
    check({pfx, "_mem_rd_wr"},   bus.mem_rd_wr, 0);
    check({pfx, "_mem_wr_data"}, bus.mem_wr_data, 0);
    check({pfx, "_busy"},        busy, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    int n_g, last_t, busy_cnt;
    logic [9:0] seq;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    bus.if_req = 1'b1; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.if_flush = 1'b0;
    bus3.dm_req = 1'b0; bus3.dm_we = 1'b0; bus3.dm_addr = '0; bus3.dm_wdata = '0;
    bus3.mem_rd_data = '0;
    reset = 1'b1;
    t = 0;
    model_reset();

    // Reset state, with requests pending to show grants are held off
    @(negedge clk);
    check_all_zero("por");
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    reset = 1'b0;

    // Single load of 0x40
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
    step();
    bus.dm_req = 1'b0;
    repeat (3) step();

    // Single store to 0x10
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h10; bus.dm_wdata = 32'h12345678;
    step();
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    repeat (3) step();

    // Both held continuously: starvation limit forces every fifth grant to fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h20;
    n_g = 0; seq = '0; last_t = -1;
    for (int c = 0; c < 60 && n_g < 10; c++) begin
      step();
      if (obs_if_gnt || obs_dm_gnt) begin
        seq[n_g] = obs_if_gnt;
        if (n_g > 0) check("grant_gap", t - 1 - last_t, LAT + 2);
        last_t = t - 1;
        n_g++;
      end
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    check("grant_count", n_g, 10);
    check("grant_order", seq, 10'b10_0001_0000);
    repeat (LAT + 2) step();

    // Fetch flushed during WAIT; the next grant lands on schedule
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step();
    bus.if_req = 1'b0;
    step();
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h44;
    step();
    bus.dm_req = 1'b0;
    repeat (3) step();

    // Reset asserted mid-WAIT of a load
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
    step();
    bus.dm_req = 1'b0;
    step();
    #2 reset = 1'b1;
    #1 check_all_zero("rst");
    model_reset();
    @(posedge clk); #1;
    t++;
    reset = 1'b0;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h48;
    step();
    bus.dm_req = 1'b0;
    repeat (3) step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if (obs_if_gnt || (bus.if_req && $urandom_range(0, 31) == 0)) bus.if_req = 1'b0;
      else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = rand_addr();
      end
      if (obs_dm_gnt || (bus.dm_req && $urandom_range(0, 31) == 0)) bus.dm_req = 1'b0;
      else if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
        bus.dm_req   = 1'b1;
        bus.dm_we    = $urandom_range(0, 1) == 1;
        bus.dm_addr  = rand_addr();
        bus.dm_wdata = $urandom;
      end
      bus.if_flush = ($urandom_range(0, 7) == 0);
      step();
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.if_flush = 1'b0;
    repeat (5) step();

    // MEM_LAT=3 instance: response 5 cycles after grant, busy for 4
    bus3.dm_req = 1'b1; bus3.dm_we = 1'b0; bus3.dm_addr = 32'h80;
    bus3.mem_rd_data = 32'h0BAD_0BAD;
    @(negedge clk);
    check("l3_dm_gnt", bus3.dm_gnt, 1);
    check("l3_busy_at_grant", busy3, 0);
    @(posedge clk); #1;
    bus3.dm_req = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      bus3.mem_rd_data = (k == LAT3 + 1) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;
      @(negedge clk);
      if (busy3) busy_cnt++;
      check("l3_mem_op_en", bus3.mem_op_en, k == 1);
      check("l3_dm_rvalid", bus3.dm_rvalid, k == LAT3 + 2);
      if (k == LAT3 + 2) check("l3_dm_rdata", bus3.dm_rdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
    end
    check("l3_busy_cycles", busy_cnt, LAT3 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
